// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised full-duplex UART core, independent TX and RX serialisers on a common bit period.
// Define UART_PARITY_EN to add a parity bit (XOR(data)^PARITY_ODD) to both directions.
module uart_xcvr_param #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              txd,
   input  logic              rxd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_parity_err,
   output logic              rx_frame_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * 2) + 1;
   localparam int unsigned IDX_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   if (DATA_W < 1 || DATA_W > 16 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
       STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_xcvr_param: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_e;

`ifdef UART_PARITY_EN
   localparam logic   PAR_SENSE  = 1'(PARITY_ODD);
   localparam state_e AFTER_DATA = S_PARITY;
`else
   localparam state_e AFTER_DATA = S_STOP;
`endif

   // ---------------- TX ----------------
   state_e            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
   logic [IDX_W-1:0]  tx_idx_q,   tx_idx_d;
   logic [DATA_W-1:0] tx_sh_q,    tx_sh_d;
`ifdef UART_PARITY_EN
   logic              tx_par_q,   tx_par_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_sh_q    <= '0;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_sh_q    <= tx_sh_d;
`ifdef UART_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_idx_d   = tx_idx_q;
      tx_sh_d    = tx_sh_q;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         S_IDLE: begin
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (tx_valid) begin
               tx_state_d = S_START;
               tx_sh_d    = tx_data;
`ifdef UART_PARITY_EN
               tx_par_d   = (^tx_data) ^ PAR_SENSE;
`endif
            end
         end
         S_START: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = S_DATA;
            tx_cnt_d   = '0;
         end
         S_DATA: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            tx_sh_d  = tx_sh_q >> 1;
            tx_idx_d = tx_idx_q + 1'b1;
            if (tx_idx_q == IDX_LAST) tx_state_d = AFTER_DATA;
         end
`ifdef UART_PARITY_EN
         S_PARITY: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = S_STOP;
            tx_cnt_d   = '0;
         end
`endif
         S_STOP: if (tx_cnt_q == STOP_LAST) tx_state_d = S_IDLE;
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_ready = (tx_state_q == S_IDLE);
      case (tx_state_q)
         S_START:  txd = 1'b0;
         S_DATA:   txd = tx_sh_q[0];
`ifdef UART_PARITY_EN
         S_PARITY: txd = tx_par_q;
`endif
         default:  txd = 1'b1;
      endcase
   end

   // ---------------- RX ----------------
   logic [1:0]        rx_sync_q;
   logic              rx_s;
   state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
   logic [IDX_W-1:0]  rx_idx_q,   rx_idx_d;
   logic [DATA_W-1:0] rx_sh_q,    rx_sh_d;
   logic [DATA_W-1:0] rx_data_q,  rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ferr_q,  rx_ferr_d;
`ifdef UART_PARITY_EN
   logic              rx_par_q,   rx_par_d;
   logic              rx_perr_q,  rx_perr_d;
`endif

   assign rx_s = rx_sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_q  <= '1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
`endif
      end else begin
         rx_sync_q  <= {rx_sync_q[0], rxd};
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
         rx_par_q   <= rx_par_d;
         rx_perr_q  <= rx_perr_d;
`endif
      end
   end

   // The start check lands half a bit in; every later sample is one full bit on, i.e. mid-bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_idx_d   = rx_idx_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = rx_ferr_q;
`ifdef UART_PARITY_EN
      rx_par_d   = rx_par_q;
      rx_perr_d  = rx_perr_q;
`endif
      case (rx_state_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            if (!rx_s) rx_state_d = S_START;
         end
         S_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d            = '0;
            rx_sh_d             = rx_sh_q >> 1;
            rx_sh_d[DATA_W-1]   = rx_s;
            rx_idx_d            = rx_idx_q + 1'b1;
            if (rx_idx_q == IDX_LAST) rx_state_d = AFTER_DATA;
         end
`ifdef UART_PARITY_EN
         S_PARITY: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_par_d   = rx_s;
            rx_state_d = S_STOP;
         end
`endif
         S_STOP: if (rx_cnt_q == BIT_LAST) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            rx_ferr_d  = ~rx_s;
`ifdef UART_PARITY_EN
            rx_perr_d  = (^rx_sh_q) ^ PAR_SENSE ^ rx_par_q;
`endif
            rx_state_d = S_IDLE;
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_data      = rx_data_q;
      rx_valid     = rx_valid_q;
      rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
      rx_parity_err = rx_perr_q;
`else
      rx_parity_err = 1'b0;
`endif
   end

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Self-checking bench for uart_xcvr_param: loopback and bench-driven RX frames against a frame-level model.
// Honours UART_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_uart_xcvr_param;
   localparam int DW   = 8;
   localparam int CPB  = 16;
   localparam int SB   = 1;
   localparam int PODD = 0;
`ifdef UART_PARITY_EN
   localparam int PAR_N = 1;
`else
   localparam int PAR_N = 0;
`endif
   localparam int NBITS = 1 + DW + PAR_N + SB;
   localparam int FRAME = CPB * NBITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          txd;
   logic          rxd;
   logic [DW-1:0] rx_data;
   logic          rx_valid;
   logic          rx_parity_err;
   logic          rx_frame_err;
   logic          loop;
   logic          rxd_drv;

   int checks   = 0;
   int failures = 0;

   assign rxd = loop ? txd : rxd_drv;

   uart_xcvr_param #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(PODD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
      .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
   );

   always #5 clk = ~clk;

   // Line level of bit period k of a frame carrying d.
   function automatic logic frame_bit(input logic [DW-1:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return d[k-1];
      if (PAR_N == 1 && k == DW + 1) return (^d) ^ (PODD != 0);
      return 1'b1;
   endfunction

   function automatic logic good_parity(input logic [DW-1:0] d);
      return (^d) ^ (PODD != 0);
   endfunction

   // Sends one frame over loopback and records what the line and the receiver did.
   task automatic tx_observe(input logic [DW-1:0] d, output logic first_txd, output int wave_err,
                             output int ready_low, output logic ready_after, output logic [NBITS-1:0] mid,
                             output int pulses, output logic [DW-1:0] got, output logic perr, output logic ferr);
      wave_err = 0; ready_low = 0; pulses = 0; got = '0; perr = 1'b0; ferr = 1'b0; mid = '0;
      loop = 1'b1;
      tx_data = d; tx_valid = 1'b1;
      @(negedge clk);
      first_txd = txd;
      for (int i = 0; i < FRAME; i++) begin
         tx_valid = (i < FRAME - 2) ? 1'($urandom) : 1'b0;
         tx_data  = DW'($urandom);
         if (txd !== frame_bit(d, i / CPB)) wave_err++;
         if (i % CPB == CPB / 2) mid[i / CPB] = txd;
         if (tx_ready !== 1'b1) ready_low++;
         if (rx_valid === 1'b1) begin pulses++; got = rx_data; perr = rx_parity_err; ferr = rx_frame_err; end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      ready_after = tx_ready;
      for (int i = 0; i < CPB; i++) begin
         if (txd !== 1'b1) wave_err++;
         if (rx_valid === 1'b1) begin pulses++; got = rx_data; perr = rx_parity_err; ferr = rx_frame_err; end
         @(negedge clk);
      end
   endtask

   // Drives one frame straight onto rxd, then idles high for two bit periods.
   task automatic rx_drive(input logic [DW-1:0] d, input logic pbit, input logic sbit,
                           output int pulses, output logic [DW-1:0] got, output logic perr, output logic ferr);
      logic bits[$];
      pulses = 0; got = '0; perr = 1'b0; ferr = 1'b0;
      loop = 1'b0;
      bits.push_back(1'b0);
      for (int k = 0; k < DW; k++) bits.push_back(d[k]);
      if (PAR_N == 1) bits.push_back(pbit);
      bits.push_back(sbit);
      for (int i = 0; i < bits.size() * CPB + 2 * CPB; i++) begin
         rxd_drv = (i < bits.size() * CPB) ? bits[i / CPB] : 1'b1;
         if (rx_valid === 1'b1) begin pulses++; got = rx_data; perr = rx_parity_err; ferr = rx_frame_err; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; loop = 1'b1; rxd_drv = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", txd); end
      checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      checks++; if (rx_data !== '0) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
      checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b want 0", rx_parity_err); end
      checks++; if (rx_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", rx_frame_err); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single;
      logic first, rdy, pe, fe; int we, rl, np; logic [NBITS-1:0] mid; logic [DW-1:0] got;
      tx_observe(8'hA5, first, we, rl, rdy, mid, np, got, pe, fe);
      checks++; if (first !== 1'b0) begin failures++; $display("FAIL single_start: txd got %b want 0", first); end
      checks++; if (we != 0) begin failures++; $display("FAIL single_wave: %0d bad cycles want 0", we); end
      checks++; if (rl != FRAME) begin failures++; $display("FAIL single_ready_low: got %0d want %0d", rl, FRAME); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL single_ready_back: got %b want 1", rdy); end
      checks++; if (np != 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", np); end
      checks++; if (got !== 8'hA5) begin failures++; $display("FAIL single_data: got %h want a5", got); end
      checks++; if (pe !== 1'b0 || fe !== 1'b0) begin failures++; $display("FAIL single_flags: got p%b f%b want p0 f0", pe, fe); end
   endtask

   task automatic test_back_to_back;
      int we = 0, np = 0; logic exp; logic [DW-1:0] got [2];
      got[0] = 'x; got[1] = 'x;
      loop = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hFF;
      for (int i = 0; i <= 2 * FRAME + CPB; i++) begin
         if (i < FRAME)           exp = frame_bit(8'h00, i / CPB);
         else if (i == FRAME)     exp = 1'b1;
         else if (i <= 2 * FRAME) exp = frame_bit(8'hFF, (i - FRAME - 1) / CPB);
         else                     exp = 1'b1;
         if (txd !== exp) we++;
         if (rx_valid === 1'b1) begin if (np < 2) got[np] = rx_data; np++; end
         if (i == FRAME + 1) tx_valid = 1'b0;
         @(negedge clk);
      end
      checks++; if (we != 0) begin failures++; $display("FAIL b2b_wave: %0d bad cycles want 0", we); end
      checks++; if (np != 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", np); end
      checks++; if (got[0] !== 8'h00) begin failures++; $display("FAIL b2b_data0: got %h want 00", got[0]); end
      checks++; if (got[1] !== 8'hFF) begin failures++; $display("FAIL b2b_data1: got %h want ff", got[1]); end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity;
      logic first, rdy, pe, fe; int we, rl, np; logic [NBITS-1:0] mid; logic [DW-1:0] got;
      tx_observe(8'hA5, first, we, rl, rdy, mid, np, got, pe, fe);
      checks++; if (mid[DW+1] !== (PODD != 0)) begin failures++; $display("FAIL par_bit: got %b want %b", mid[DW+1], PODD != 0); end
      checks++; if (np != 1 || pe !== 1'b0) begin failures++; $display("FAIL par_ok: pulses %0d perr %b want 1 0", np, pe); end
      rx_drive(8'hA5, ~good_parity(8'hA5), 1'b1, np, got, pe, fe);
      checks++; if (np != 1 || got !== 8'hA5) begin failures++; $display("FAIL par_bad_rx: pulses %0d data %h want 1 a5", np, got); end
      checks++; if (pe !== 1'b1) begin failures++; $display("FAIL par_bad_flag: got %b want 1", pe); end
   endtask
`endif

   task automatic test_frame_err;
      int np; logic pe, fe; logic [DW-1:0] got, d;
      rx_drive(8'h3C, good_parity(8'h3C), 1'b0, np, got, pe, fe);
      checks++; if (np != 1) begin failures++; $display("FAIL ferr_pulses: got %0d want 1", np); end
      checks++; if (got !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h want 3c", got); end
      checks++; if (fe !== 1'b1 || pe !== 1'b0) begin failures++; $display("FAIL ferr_flags: got f%b p%b want f1 p0", fe, pe); end
      d = DW'($urandom);
      rx_drive(d, good_parity(d), 1'b1, np, got, pe, fe);
      checks++; if (np != 1 || got !== d) begin failures++; $display("FAIL ferr_clean: pulses %0d data %h want 1 %h", np, got, d); end
      checks++; if (fe !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b want 0", fe); end
   endtask

   task automatic test_glitch;
      int np = 0; logic pe, fe; logic [DW-1:0] got, d;
      loop = 1'b0;
      for (int i = 0; i < 3 * CPB + 4; i++) begin
         rxd_drv = (i < 4) ? 1'b0 : 1'b1;
         if (rx_valid === 1'b1) np++;
         @(negedge clk);
      end
      checks++; if (np != 0) begin failures++; $display("FAIL glitch_pulses: got %0d want 0", np); end
      d = DW'($urandom);
      rx_drive(d, good_parity(d), 1'b1, np, got, pe, fe);
      checks++; if (np != 1 || got !== d || fe !== 1'b0) begin
         failures++; $display("FAIL glitch_after: pulses %0d data %h ferr %b want 1 %h 0", np, got, fe, d);
      end
   endtask

   task automatic test_reset_midframe;
      logic first, rdy, pe, fe; int we, rl, np = 0; logic [NBITS-1:0] mid; logic [DW-1:0] got;
      loop = 1'b1; tx_data = DW'($urandom); tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (5 * CPB) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (txd !== 1'b1 || tx_ready !== 1'b1) begin
         failures++; $display("FAIL rst_mid_tx: txd %b ready %b want 1 1", txd, tx_ready);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3 * CPB; i++) begin
         if (rx_valid === 1'b1) np++;
         @(negedge clk);
      end
      checks++; if (np != 0) begin failures++; $display("FAIL rst_mid_spurious: got %0d pulses want 0", np); end
      tx_observe(8'h5A, first, we, rl, rdy, mid, np, got, pe, fe);
      checks++; if (we != 0 || np != 1 || got !== 8'h5A || pe !== 1'b0 || fe !== 1'b0) begin
         failures++; $display("FAIL rst_mid_after: wave %0d pulses %0d data %h p%b f%b want 0 1 5a p0 f0", we, np, got, pe, fe);
      end
   endtask

   task automatic test_random;
      logic first, rdy, pe, fe, pb, sb; int we, rl, np; logic [NBITS-1:0] mid; logic [DW-1:0] got, d;
      for (int n = 0; n < 5; n++) begin
         d = DW'($urandom);
         tx_observe(d, first, we, rl, rdy, mid, np, got, pe, fe);
         checks++; if (we != 0 || np != 1 || got !== d || pe !== 1'b0 || fe !== 1'b0) begin
            failures++; $display("FAIL rand_loop[%0d]: wave %0d pulses %0d data %h p%b f%b want 0 1 %h p0 f0", n, we, np, got, pe, fe, d);
         end
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      for (int n = 0; n < 6; n++) begin
         d  = DW'($urandom);
         pb = good_parity(d) ^ 1'($urandom);
         sb = 1'($urandom);
         rx_drive(d, pb, sb, np, got, pe, fe);
         checks++; if (np != 1 || got !== d || fe !== ~sb || pe !== (PAR_N == 1 && pb != good_parity(d))) begin
            failures++; $display("FAIL rand_rx[%0d]: pulses %0d data %h p%b f%b want 1 %h p%b f%b",
                                 n, np, got, pe, fe, d, PAR_N == 1 && pb != good_parity(d), ~sb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
`ifdef UART_PARITY_EN
      test_parity();
`endif
      test_frame_err();
      test_glitch();
      test_reset_midframe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
